// File: rtl/idit4_seq.sv
// rtl/idit4_seq.sv - 4-point radix-2 DIT inverse DFT on one shared butterfly; define IDIT_SCALE_EN for 1/4 scaling
module idit4_seq #(
    parameter int W = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_ST1    = 2'd1,
        S_ST2    = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_cnt;
    logic signed [W-1:0] r_re [4];
    logic signed [W-1:0] r_im [4];

    logic                w_accept;
    logic                w_xfer;
    logic [1:0]          w_ia;
    logic [1:0]          w_ib;
    logic                w_jmul;
    logic [1:0]          w_oidx;
    logic signed [W:0]   w_ar, w_ai, w_xr, w_xi, w_br, w_bi;
    logic signed [W:0]   w_sr, w_si, w_dr, w_di;

    // Stage results leave the W+1-bit adder either halved (floor) or wrapped.
    function automatic logic signed [W-1:0] reduce(input logic signed [W:0] v);
`ifdef IDIT_SCALE_EN
        return W'(v >>> 1);
`else
        return W'(v);
`endif
    endfunction

    assign w_accept = in_valid & in_ready;
    assign w_xfer   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = (r_cnt != 2'd0);
                if (w_accept && r_cnt == 2'd3) w_next = S_ST1;
            end
            S_ST1: begin
                if (r_cnt == 2'd1) w_next = S_ST2;
            end
            S_ST2: begin
                if (r_cnt == 2'd3) w_next = S_UNLOAD;
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                if (w_xfer && r_cnt == 2'd3) w_next = S_LOAD;
            end
        endcase
    end

    // r_cnt keeps running through ST1 (0,1) and ST2 (2,3), so r_cnt[0] is the
    // sub-cycle. ST1 pairs (0,2),(1,3); ST2 pairs (0,1),(2,3) with +j on the
    // second pair, leaving the buffer as x0,x2,x1,x3 (bit-reversed).
    always_comb begin
        if (r_state == S_ST2) begin
            w_ia   = {r_cnt[0], 1'b0};
            w_ib   = {r_cnt[0], 1'b1};
            w_jmul = r_cnt[0];
        end else begin
            w_ia   = {1'b0, r_cnt[0]};
            w_ib   = {1'b1, r_cnt[0]};
            w_jmul = 1'b0;
        end
        w_ar = {r_re[w_ia][W-1], r_re[w_ia]};
        w_ai = {r_im[w_ia][W-1], r_im[w_ia]};
        w_xr = {r_re[w_ib][W-1], r_re[w_ib]};
        w_xi = {r_im[w_ib][W-1], r_im[w_ib]};
        if (w_jmul) begin
            w_br = -w_xi;
            w_bi = w_xr;
        end else begin
            w_br = w_xr;
            w_bi = w_xi;
        end
        w_sr = w_ar + w_br;
        w_si = w_ai + w_bi;
        w_dr = w_ar - w_br;
        w_di = w_ai - w_bi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_re[r_cnt] <= in_re;
                        r_im[r_cnt] <= in_im;
                        r_cnt       <= r_cnt + 2'd1;
                    end
                end
                S_ST1, S_ST2: begin
                    r_re[w_ia] <= reduce(w_sr);
                    r_im[w_ia] <= reduce(w_si);
                    r_re[w_ib] <= reduce(w_dr);
                    r_im[w_ib] <= reduce(w_di);
                    r_cnt      <= r_cnt + 2'd1;
                end
                S_UNLOAD: begin
                    if (w_xfer) r_cnt <= r_cnt + 2'd1;
                end
            endcase
        end
    end

    assign w_oidx = {r_cnt[0], r_cnt[1]};
    assign out_re = r_re[w_oidx];
    assign out_im = r_im[w_oidx];

endmodule

// File: tb/tb_idit4_seq.sv
// tb/tb_idit4_seq.sv - self-checking bench for idit4_seq (vector table, hand sequences, random frames vs model)
module tb_idit4_seq;
    localparam int W = 9;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re;
    logic signed [W-1:0] in_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic                busy;

    int checks = 0;
    int errors = 0;

    idit4_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string nm;
        int    xr[4];
        int    xi[4];
        int    er[4];
        int    ei[4];
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int wrap(input int v);
        int m;
        m = v & ((1 << W) - 1);
        return (m >= (1 << (W - 1))) ? m - (1 << W) : m;
    endfunction

    function automatic int half(input int v);
        return v >>> 1;
    endfunction

    // Reference: unscaled result is the exact IDFT sum reduced mod 2^W;
    // scaled result applies floor-halving after each butterfly stage.
    task automatic model(input int xr[4], input int xi[4], output int yr[4], output int yi[4]);
`ifdef IDIT_SCALE_EN
        int a0r, a0i, a1r, a1i, a2r, a2i, a3r, a3i;
        a0r = half(xr[0] + xr[2]); a0i = half(xi[0] + xi[2]);
        a1r = half(xr[0] - xr[2]); a1i = half(xi[0] - xi[2]);
        a2r = half(xr[1] + xr[3]); a2i = half(xi[1] + xi[3]);
        a3r = half(xr[1] - xr[3]); a3i = half(xi[1] - xi[3]);
        yr[0] = half(a0r + a2r); yi[0] = half(a0i + a2i);
        yr[2] = half(a0r - a2r); yi[2] = half(a0i - a2i);
        yr[1] = half(a1r - a3i); yi[1] = half(a1i + a3r);
        yr[3] = half(a1r + a3i); yi[3] = half(a1i - a3r);
`else
        for (int n = 0; n < 4; n++) begin
            int sr, si;
            sr = 0;
            si = 0;
            for (int k = 0; k < 4; k++) begin
                case ((n * k) % 4)
                    0: begin sr += xr[k]; si += xi[k]; end
                    1: begin sr -= xi[k]; si += xr[k]; end
                    2: begin sr -= xr[k]; si -= xi[k]; end
                    default: begin sr += xi[k]; si -= xr[k]; end
                endcase
            end
            yr[n] = wrap(sr);
            yi[n] = wrap(si);
        end
`endif
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic push(input int re, input int im);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_re    = W'(re);
        in_im    = W'(im);
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready got 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int xr[4], input int xi[4], input bit gap);
        for (int k = 0; k < 4; k++) begin
            push(xr[k], xi[k]);
            if (gap && k < 3) @(negedge clk);
        end
    endtask

    // Collects one frame; bp selects an output index to stall for 5 cycles (-1: none).
    task automatic collect(input int er[4], input int ei[4], input string nm,
                           input int bp, input bit chk_lat);
        int lat;
        int hold_re, hold_im;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (chk_lat) chk({nm, "_latency"}, lat, 4);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("%s_x%0d_valid", nm, n), int'(out_valid), 1);
            chk($sformatf("%s_x%0d_re", nm, n), int'(out_re), er[n]);
            chk($sformatf("%s_x%0d_im", nm, n), int'(out_im), ei[n]);
            if (n == bp) begin
                hold_re   = int'(out_re);
                hold_im   = int'(out_im);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk($sformatf("%s_bp_valid", nm), int'(out_valid), 1);
                    chk($sformatf("%s_bp_hold_re", nm), int'(out_re), hold_re);
                    chk($sformatf("%s_bp_hold_im", nm), int'(out_im), hold_im);
                    chk($sformatf("%s_bp_in_ready", nm), int'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk({nm, "_in_ready_after"}, int'(in_ready), 1);
        chk({nm, "_out_valid_after"}, int'(out_valid), 0);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_in_ready"}, int'(in_ready), 1);
        chk({nm, "_out_valid"}, int'(out_valid), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_out_re"}, int'(out_re), 0);
        chk({nm, "_out_im"}, int'(out_im), 0);
    endtask

    vec_t tbl[3];
    int   xr[4], xi[4], yr[4], yi[4];
    int   imp_r[4], imp_i[4], imp_er[4], imp_ei[4];

    initial begin
        tbl[0].nm = "impulse_x0";
        tbl[0].xr = '{64, 0, 0, 0};     tbl[0].xi = '{0, 0, 0, 0};
        tbl[1].nm = "impulse_x1";
        tbl[1].xr = '{0, 64, 0, 0};     tbl[1].xi = '{0, 0, 0, 0};
        tbl[2].nm = "dc_200";
        tbl[2].xr = '{200, 200, 200, 200}; tbl[2].xi = '{0, 0, 0, 0};
`ifdef IDIT_SCALE_EN
        tbl[0].er = '{16, 16, 16, 16};  tbl[0].ei = '{0, 0, 0, 0};
        tbl[1].er = '{16, 0, -16, 0};   tbl[1].ei = '{0, 16, 0, -16};
        tbl[2].er = '{200, 0, 0, 0};    tbl[2].ei = '{0, 0, 0, 0};
`else
        tbl[0].er = '{64, 64, 64, 64};  tbl[0].ei = '{0, 0, 0, 0};
        tbl[1].er = '{64, 0, -64, 0};   tbl[1].ei = '{0, 64, 0, -64};
        tbl[2].er = '{-224, 0, 0, 0};   tbl[2].ei = '{0, 0, 0, 0};
`endif
        imp_r  = tbl[0].xr; imp_i  = tbl[0].xi;
        imp_er = tbl[0].er; imp_ei = tbl[0].ei;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            send_frame(tbl[v].xr, tbl[v].xi, 1'b0);
            collect(tbl[v].er, tbl[v].ei, tbl[v].nm, -1, 1'b1);
        end

        // Back-pressure on x1
        send_frame(tbl[1].xr, tbl[1].xi, 1'b0);
        collect(tbl[1].er, tbl[1].ei, "backpressure", 1, 1'b1);

        // Reset after two accepted samples, then a clean impulse frame
        push(100, -50);
        push(-77, 33);
        chk("partial_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(imp_r, imp_i, 1'b0);
        collect(imp_er, imp_ei, "after_reset", -1, 1'b1);

        // Reset while a frame is being unloaded: nothing of it may reappear
        xr = '{11, -22, 33, -44}; xi = '{5, 6, 7, 8};
        send_frame(xr, xi, 1'b0);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("unload_before_reset_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("unload_reset");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_no_output", int'(out_valid), 0);
        end
        send_frame(imp_r, imp_i, 1'b0);
        collect(imp_er, imp_ei, "after_unload_reset", -1, 1'b1);

        // Gapped frame with in_valid junk during processing, then back-to-back frame
        xr = '{-100, 37, 120, -5}; xi = '{9, -80, 44, 3};
        model(xr, xi, yr, yi);
        send_frame(xr, xi, 1'b1);
        in_valid = 1'b1;
        in_re    = W'(77);
        in_im    = W'(-77);
        @(negedge clk);
        chk("ignored_in_ready", int'(in_ready), 0);
        collect(yr, yi, "gapped", -1, 1'b0);
        in_valid = 1'b0;
        xr = '{3, -3, 250, -256}; xi = '{-1, 255, 0, 17};
        model(xr, xi, yr, yi);
        send_frame(xr, xi, 1'b1);
        collect(yr, yi, "back_to_back", -1, 1'b1);

        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < 4; k++) begin
                xr[k] = int'($urandom_range(0, 511)) - 256;
                xi[k] = int'($urandom_range(0, 511)) - 256;
            end
            model(xr, xi, yr, yi);
            send_frame(xr, xi, 1'($urandom_range(0, 1)));
            collect(yr, yi, $sformatf("rand%0d", f), int'($urandom_range(0, 4)) - 1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idit4_seq.md
IDIT4_SEQ -- requirements
Module: idit4_seq

Interface
REQ-001 SHALL have parameter W, default 9, meaning the signed two's-complement width of each real/imag sample.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  an input sample is present.
REQ-005 SHALL have port in_ready  output  1  the block accepts an input sample this cycle.
REQ-006 SHALL have port in_re, in_im  input  W each  the input frequency-domain sample, signed.
REQ-007 SHALL have port out_valid  output  1  an output sample is present.
REQ-008 SHALL have port out_ready  input  1  the downstream consumer accepts the output sample.
REQ-009 SHALL have port out_re, out_im  output  W each  the output time-domain sample, signed.
REQ-010 SHALL have port busy  output  1  high in every state except LOAD with zero samples held.

Function
REQ-011 SHALL compute a 4-point radix-2 DIT inverse DFT on frames of 4 complex samples X0..X3, accepted in natural order.
REQ-012 SHALL use one shared butterfly datapath, time-multiplexed, with states LOAD -> ST1 -> ST2 -> UNLOAD -> LOAD.
REQ-013 LOAD: in_ready=1; a sample is accepted on an edge with in_valid&in_ready; a 2-bit count runs 0..3; the 4th accept moves to ST1.
REQ-014 ST1 SHALL take 2 cycles: A0=X0+X2, A1=X0-X2 in cycle 1; A2=X1+X3, A3=X1-X3 in cycle 2; results overwrite the sample buffer in place.
REQ-015 ST2 SHALL take 2 cycles: x0=A0+A2, x2=A0-A2 in cycle 1; x1=A1+j*A3, x3=A1-j*A3 in cycle 2, where j*(r+ji) = (-i)+j(r).
REQ-016 The twiddle factor SHALL be conjugated (W4^-1=+j); no multiplier is instantiated.
REQ-017 Each add/sub SHALL be formed at W+1 bits and then reduced to W bits per REQ-027.
REQ-018 UNLOAD: out_valid=1 with x0,x1,x2,x3 presented in natural order; advance on edge with out_valid&out_ready; after x3 transfers, return to LOAD.
REQ-019 Latency: 4th input accepted at edge N -> out_valid=1 with x0 after edge N+4.
REQ-020 in_ready SHALL be 0 in ST1, ST2, UNLOAD; in_valid is ignored there.
REQ-021 out_valid SHALL be 0 outside UNLOAD; out_re/out_im SHALL hold their value and stay stable while out_valid=1 and out_ready=0.
REQ-022 A gap in in_valid mid-frame SHALL hold count and buffer; no timeout.
REQ-023 After the last output transfers, in_ready SHALL rise in the following cycle; there is no overlap of LOAD and UNLOAD.

Reset
REQ-024 rst_n low SHALL immediately force LOAD, count=0, in_ready=1, out_valid=0, busy=0, out_re=out_im=0, and the buffer cleared to 0.
REQ-025 Reset asserted mid-frame in any state SHALL discard the partial frame; no output of that frame is presented after release.
REQ-026 After rst_n deasserts, the first in_valid sample SHALL be taken as X0.

Configuration
REQ-027 With macro IDIT_SCALE_EN defined, each stage result SHALL be arithmetically shifted right by 1 (floor) from W+1 to W bits, giving the 1/4 IDFT scaling overall and no overflow; without it, results SHALL keep the low W bits (two's-complement wrap, unscaled).

Verification
REQ-028 Impulse X0=(64,0), X1..X3=0 -> with IDIT_SCALE_EN: four outputs (16,0); without: four outputs (64,0).
REQ-029 X1=(64,0), others 0, IDIT_SCALE_EN -> (16,0),(0,16),(-16,0),(0,-16); without -> (64,0),(0,64),(-64,0),(0,-64).
REQ-030 All Xk=(200,0), no IDIT_SCALE_EN -> x0=(-224,0) (800 wrapped), x1..x3=(0,0); with IDIT_SCALE_EN -> x0=(200,0), x1..x3=(0,0).
REQ-031 Back-pressure: out_ready=0 for 5 cycles during x1 -> out_valid stays 1, x1 held stable, in_ready=0; on release x1..x3 follow one per cycle.
REQ-032 Reset pulse after 2 inputs accepted, then a full frame of the REQ-028 impulse -> only the 4 outputs of the new frame appear, with no residue from the discarded samples.
REQ-033 Gapped input (in_valid toggling 1,0,1,0...) and two back-to-back frames -> correct results; first output 4 cycles after the 4th accept each frame.
